// File: rtl/led_pkg.sv
// Shared mode encoding and default widths for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  localparam int DEF_DIV_W = 5;
  localparam int DEF_PWM_W = 8;

endpackage

// File: rtl/led_chan.sv
// One LED channel: configuration registers, power-of-two prescaler,
// blink toggle and PWM phase counter feeding a registered LED drive.
module led_chan
  import led_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int PWM_W = DEF_PWM_W
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             clr_i,
  input  led_mode_t        mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [PWM_W-1:0] duty_i,
  output logic             led_o
);

  // Wide enough to count up to 2^max_div - 1 for the largest exponent.
  localparam int PRE_W = (1 << DIV_W) - 1;

  function automatic logic [PRE_W-1:0] tick_mask(input logic [DIV_W-1:0] d);
    logic [PRE_W-1:0] m;
    for (int i = 0; i < PRE_W; i++) begin
      m[i] = (i < int'(d));
    end
    return m;
  endfunction

  led_mode_t        mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             blink_q, blink_d;
  logic             led_q, led_d;
  logic             tick;

  always_comb begin
    tick    = (pre_q == tick_mask(div_q));
    mode_d  = mode_q;
    div_d   = div_q;
    duty_d  = duty_q;
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    pwm_d   = tick ? pwm_q + PWM_W'(1) : pwm_q;
    blink_d = tick ? ~blink_q : blink_q;

    if (wr_i) begin
      mode_d = mode_i;
      div_d  = div_i;
      duty_d = duty_i;
    end
    // A write restarts only its own channel; sync restarts every channel.
    if (wr_i || clr_i) begin
      pre_d   = '0;
      pwm_d   = '0;
      blink_d = 1'b0;
    end

    unique case (mode_q)
      LED_OFF:   led_d = 1'b0;
      LED_ON:    led_d = 1'b1;
      LED_BLINK: led_d = blink_q;
      LED_PWM:   led_d = (pwm_q < duty_q);
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      mode_q  <= LED_OFF;
      div_q   <= '0;
      duty_q  <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_cnt_multi.sv
// Multi-channel LED driver: decodes the shared write port into one-hot
// channel writes and fans sync out to every channel.
module led_cnt_multi
  import led_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int PWM_W  = DEF_PWM_W,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              wren_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  input  logic [1:0]        mode_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [PWM_W-1:0]  duty_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] led_o
);

  logic [NUM_CH-1:0] wr_vec;
  logic              sel_ok;

  // Selects at or beyond NUM_CH are dropped rather than aliased onto a channel.
  assign sel_ok = (int'(ch_sel_i) < NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_vec[c] = wren_i && sel_ok && (int'(ch_sel_i) == c);

    led_chan #(
      .DIV_W (DIV_W),
      .PWM_W (PWM_W)
    ) u_chan (
      .clk100 (clk100),
      .rst    (rst),
      .wr_i   (wr_vec[c]),
      .clr_i  (sync_i),
      .mode_i (led_mode_t'(mode_i)),
      .div_i  (div_i),
      .duty_i (duty_i),
      .led_o  (led_o[c])
    );
  end

endmodule

// File: tb/tb_led_cnt_multi.sv
// Scoreboard bench for led_cnt_multi: stimulus pushes the expected led_o for
// each upcoming edge, a monitor pops and compares just after that edge.
`timescale 1ns/1ps
module tb_led_cnt_multi;
  import led_pkg::*;

  logic       clk100 = 1'b0;
  logic       rst;
  logic       wren_i;
  logic [2:0] ch_sel_i;
  logic [1:0] mode_i;
  logic [4:0] div_i;
  logic [7:0] duty_i;
  logic       sync_i;
  logic [3:0] led_o;

  always #5 clk100 = ~clk100;

  led_cnt_multi #(
    .NUM_CH (4),
    .DIV_W  (5),
    .PWM_W  (8),
    .SEL_W  (3)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .wren_i   (wren_i),
    .ch_sel_i (ch_sel_i),
    .mode_i   (mode_i),
    .div_i    (div_i),
    .duty_i   (duty_i),
    .sync_i   (sync_i),
    .led_o    (led_o)
  );

  typedef struct {
    logic [3:0] exp;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_t;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: led_o is valid every cycle, so one expectation per edge.
  initial begin
    forever begin
      @(posedge clk100);
      #1;
      if (sb_q.size() > 0) begin
        mon_t = sb_q.pop_front();
        checks++;
        if (led_o !== mon_t.exp) begin
          failures++;
          $display("FAIL %s: led_o=%b expected %b at %0t", mon_t.nm, led_o, mon_t.exp, $time);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [3:0] e, input string nm);
    exp_t t;
    t.exp = e;
    t.nm  = nm;
    sb_q.push_back(t);
    @(negedge clk100);
  endtask

  task automatic set_wr(input int ch, input logic [1:0] m, input int d, input int du);
    wren_i   = 1'b1;
    ch_sel_i = 3'(ch);
    mode_i   = m;
    div_i    = 5'(d);
    duty_i   = 8'(du);
  endtask

  task automatic clr_strobes();
    wren_i = 1'b0;
    sync_i = 1'b0;
  endtask

  initial begin
    logic b;
    logic p;
    rst = 1'b1; wren_i = 1'b0; sync_i = 1'b0;
    ch_sel_i = '0; mode_i = '0; div_i = '0; duty_i = '0;
    @(negedge clk100);

    for (int i = 0; i < 3; i++) cyc(4'b0000, "reset");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) cyc(4'b0000, "post_reset");

    // ON, out-of-range writes, OFF
    set_wr(2, LED_ON, 0, 0);
    cyc(4'b0000, "ch2_on_edge");
    clr_strobes();
    for (int i = 0; i < 3; i++) cyc(4'b0100, "ch2_on");
    set_wr(5, LED_ON, 0, 0);
    cyc(4'b0100, "oor5_edge");
    clr_strobes();
    for (int i = 0; i < 3; i++) cyc(4'b0100, "oor5_hold");
    set_wr(4, LED_ON, 0, 0);
    cyc(4'b0100, "oor4_edge");
    clr_strobes();
    for (int i = 0; i < 3; i++) cyc(4'b0100, "oor4_hold");
    set_wr(2, LED_OFF, 0, 0);
    cyc(4'b0100, "ch2_off_edge");
    clr_strobes();
    for (int i = 0; i < 2; i++) cyc(4'b0000, "ch2_off");

    // BLINK div=3: low through k+8, high k+9..k+16, period 16
    set_wr(0, LED_BLINK, 3, 0);
    cyc(4'b0000, "blink_edge");
    clr_strobes();
    for (int n = 1; n <= 40; n++) begin
      b = (((n - 1) >> 3) % 2) == 1;
      cyc({3'b000, b}, "blink_div3");
    end
    set_wr(0, LED_OFF, 0, 0);
    cyc(4'b0001, "blink_off_edge");
    clr_strobes();
    cyc(4'b0000, "blink_off");

    // PWM div=0 duty=64: high for the first 64 slots of each 256-slot frame
    set_wr(1, LED_PWM, 0, 64);
    cyc(4'b0000, "pwm64_edge");
    clr_strobes();
    for (int n = 1; n <= 512; n++) begin
      p = ((n - 1) % 256) < 64;
      cyc({2'b00, p, 1'b0}, "pwm64");
    end
    set_wr(1, LED_PWM, 0, 0);
    cyc(4'b0010, "pwm0_edge");
    clr_strobes();
    for (int n = 1; n <= 300; n++) cyc(4'b0000, "pwm0");
    set_wr(1, LED_PWM, 0, 255);
    cyc(4'b0000, "pwm255_edge");
    clr_strobes();
    for (int n = 1; n <= 512; n++) begin
      p = ((n - 1) % 256) < 255;
      cyc({2'b00, p, 1'b0}, "pwm255");
    end
    set_wr(1, LED_OFF, 0, 0);
    cyc(4'b0010, "pwm255_off_edge");
    clr_strobes();
    cyc(4'b0000, "pwm_off");

    // Reset in the middle of activity, with a write attempted during reset
    set_wr(0, LED_BLINK, 0, 0);
    cyc(4'b0000, "mid_ch0_edge");
    set_wr(1, LED_ON, 0, 0);
    cyc(4'b0000, "mid_ch1_edge");
    clr_strobes();
    cyc(4'b0011, "mid_run");
    cyc(4'b0010, "mid_run");
    cyc(4'b0011, "mid_run");
    rst = 1'b1;
    cyc(4'b0000, "mid_reset");
    set_wr(2, LED_ON, 0, 0);
    sync_i = 1'b1;
    cyc(4'b0000, "mid_reset_wr");
    clr_strobes();
    cyc(4'b0000, "mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(4'b0000, "after_mid_reset");

    // Sync with simultaneous write: ch0/ch3 blink div=2 written 3 cycles apart
    set_wr(0, LED_BLINK, 2, 0);
    cyc(4'b0000, "sync_ch0_edge");
    clr_strobes();
    cyc(4'b0000, "pre_sync");
    cyc(4'b0000, "pre_sync");
    set_wr(3, LED_BLINK, 2, 0);
    cyc(4'b0000, "sync_ch3_edge");
    clr_strobes();
    cyc(4'b0000, "pre_sync");
    cyc(4'b0001, "pre_sync");
    cyc(4'b0001, "pre_sync");
    cyc(4'b0001, "pre_sync");
    set_wr(1, LED_ON, 0, 0);
    sync_i = 1'b1;
    cyc(4'b1001, "sync_edge");
    clr_strobes();
    for (int n = 1; n <= 32; n++) begin
      b = (((n - 1) >> 2) % 2) == 1;
      cyc({b, 1'b0, 1'b1, b}, "post_sync");
    end

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_cnt_multi.md
Name: led_cnt_multi

Overview:
- Parametrised, multi-channel successor to the single-LED divided blinker.
- Drives NUM_CH LED outputs from the 100 MHz fabric clock.
- Each channel is independently configured through a write port with mode (OFF / ON / BLINK / PWM), a power-of-two divider and a PWM duty value.
- Sits between register/debug logic and board LED pins; also serves as the visible heartbeat for DMA test designs.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- DIV_W, 5, width of divider exponent; tick period is 2^div cycles.
- PWM_W, 8, width of PWM duty and PWM phase counter.
- SEL_W, $clog2(NUM_CH) (min 1), width of channel select.

Ports:
- clk100  input  1  fabric clock, 100 MHz; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wren_i  input  1  one-cycle write strobe; captures ch_sel_i/mode_i/div_i/duty_i.
- ch_sel_i  input  SEL_W  target channel of the write.
- mode_i  input  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- div_i  input  DIV_W  divider exponent; tick every 2^div_i cycles.
- duty_i  input  PWM_W  PWM high count out of 2^PWM_W slots.
- sync_i  input  1  one-cycle pulse; restarts phase of all channels.
- led_o  output  NUM_CH  registered LED drive, bit c = channel c.

Behaviour:
- Reset (rst=1 at an edge):
  - All channels: mode=OFF, div=0, duty=0, pre_cnt=0, pwm_cnt=0, blink_q=0.
  - led_o=0 on the following cycle.
  - Reset overrides wren_i and sync_i, and is effective mid-blink/mid-PWM.
- Per-channel state:
  - cfg registers: mode, div, duty.
  - pre_cnt: width 2^DIV_W-1 bits, sized to hold 2^max_div-1.
  - pwm_cnt: PWM_W bits.
  - blink_q: 1 bit.
- Tick:
  - tick_c=1 in a cycle where pre_cnt==2^div-1.
  - pre_cnt increments every cycle and wraps to 0 on tick.
  - div=0 gives a tick every cycle.
- Write:
  - wren_i=1 at edge k with ch_sel_i<NUM_CH loads mode/div/duty into that channel.
  - The same edge clears that channel's pre_cnt, pwm_cnt and blink_q.
  - ch_sel_i>=NUM_CH: write silently ignored, no state change.
  - Other channels are never disturbed by a write.
- Output register: led_o[c] is registered from the channel state, one cycle of latency.
  - OFF: led_o[c]=0 from edge k+1.
  - ON: led_o[c]=1 from edge k+1.
  - BLINK:
    - blink_q toggles on each tick.
    - After a write at edge k, first toggle occurs at edge k+2^div; led_o rises at edge k+2^div+1.
    - Period is 2^(div+1) cycles, 50% duty.
    - div=0 gives a 0,1,0,1 pattern starting 0 at k+1.
  - PWM:
    - pwm_cnt increments (wraps at 2^PWM_W) on each tick.
    - led_o[c] = (pwm_cnt < duty), registered.
    - duty=0 is always off.
    - duty=2^PWM_W-1 is low for exactly one slot per frame.
    - Frame length is 2^PWM_W * 2^div cycles.
- Counters in OFF/ON modes: keep running but have no visible effect.
- sync_i=1 at an edge clears pre_cnt, pwm_cnt and blink_q of every channel; cfg is unchanged.
  - Channels with identical cfg are phase-aligned afterwards.
- wren_i and sync_i in the same cycle: both apply. The selected channel gets new cfg; all channels get cleared phase.
- Mode change mid-period takes effect per the write rules above; no glitch beyond the one-cycle output latency.
- No combinational path from any input to led_o.

Decomposition:
- Package led_pkg:
  - Mode constants LED_OFF=2'd0, LED_ON=2'd1, LED_BLINK=2'd2, LED_PWM=2'd3.
  - led_mode_t typedef (2-bit).
  - Default DIV_W/PWM_W values.
- Sub-module led_chan (params DIV_W, PWM_W):
  - Holds one channel's cfg, pre_cnt, pwm_cnt and blink_q.
  - Inputs: wr (already decoded), clr (sync), cfg fields.
  - Output: registered led.
- Top level:
  - Generate-loop of NUM_CH led_chan instances.
  - Write decode: ch_sel_i < NUM_CH, one-hot wr to instances.

Test Plan:
- Reset behaviour: assert rst 3 cycles mid-activity -> led_o=0 one cycle after the reset edge; all channels OFF until written.
- ON then OFF, and out-of-range write:
  - Write ch2 ON at edge k -> led_o=4'b0100 from k+1.
  - Write ch2 OFF -> 0 one cycle later.
  - Write ch_sel=5 with NUM_CH=4 -> no change.
- BLINK timing: write ch0 BLINK div=3 at edge k -> led_o[0]=0 through k+8, rises at k+9, falls at k+17; period 16 cycles.
- PWM: write ch1 PWM div=0 duty=64, PWM_W=8 -> over each 256-cycle frame, led_o[1] high exactly 64 cycles, starting at k+1.
- PWM boundaries: duty=0 -> never high; duty=255 -> exactly 1 low cycle per 256.
- Sync and simultaneous events:
  - ch0 and ch3 in BLINK div=2, written 3 cycles apart; pulse sync_i together with wren_i to ch1 ON -> ch0 and ch3 toggle on identical cycles thereafter.
  - ch1=1 from the next cycle.
